// File: rtl/axi4lite_arb2_if.sv
// AXI4-Lite bus bundle shared by the two upstream masters and the downstream slave of axi4lite_arb2.
`ifndef ALEN
`define ALEN 48
`endif

interface axi4lite_arb2_if #(
  parameter int ADDR_W = `ALEN,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4lite_arb2.sv
// 2:1 AXI4-Lite arbiter: independent round-robin read and write channels, one transaction
// outstanding per channel, zero-latency pass-through of address, data and response.
`ifndef ALEN
`define ALEN 48
`endif

module axi4lite_arb2_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic valid_i,
  input logic ready_i
);
  // A raised upstream valid must be held until its handshake.
  a_valid_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_i) |=> valid_i);
endmodule

module axi4lite_arb2 #(
  parameter int ADDR_W = `ALEN,
  parameter int DATA_W = 64
) (
  input logic              aclk,
  input logic              aresetn,
  axi4lite_arb2_if.slave   m0,
  axi4lite_arb2_if.slave   m1,
  axi4lite_arb2_if.master  s
);

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_RESP = 2'd2} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_XFER = 2'd1, WR_RESP = 2'd2} wr_state_e;

  rd_state_e rd_state_q;
  wr_state_e wr_state_q;
  logic      rd_gnt_q, last_rd_q;
  logic      wr_gnt_q, last_wr_q;
  logic      aw_done_q, w_done_q;
  logic      aw_done_d, w_done_d;

  logic              rd_addr_st_s, rd_resp_st_s, rd_pick_s;
  logic              s_arvalid_s, s_rready_s, ar_hs_s, r_hs_s, g_rready_s;
  logic [ADDR_W-1:0] g_araddr_s;
  logic              wr_xfer_st_s, wr_resp_st_s, wr_pick_s;
  logic              s_awvalid_s, s_wvalid_s, s_bready_s, aw_hs_s, w_hs_s, b_hs_s;
  logic              awready_s, wready_s, g_bready_s;
  logic [ADDR_W-1:0] g_awaddr_s;

  // Both requesting: the one not served last wins; otherwise whoever asks.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    logic gnt;
    if (req0 && req1) begin
      gnt = ~last;
    end else if (req1) begin
      gnt = 1'b1;
    end else begin
      gnt = 1'b0;
    end
    return gnt;
  endfunction

  assign rd_pick_s = rr_pick(m0.arvalid, m1.arvalid, last_rd_q);
  assign wr_pick_s = rr_pick(m0.awvalid || m0.wvalid, m1.awvalid || m1.wvalid, last_wr_q);

  // Read channel routing.
  always_comb begin
    rd_addr_st_s = (rd_state_q == RD_ADDR);
    rd_resp_st_s = (rd_state_q == RD_RESP);
    g_araddr_s   = rd_gnt_q ? m1.araddr : m0.araddr;
    s_arvalid_s  = rd_addr_st_s && (rd_gnt_q ? m1.arvalid : m0.arvalid);
    g_rready_s   = rd_gnt_q ? m1.rready : m0.rready;
    s_rready_s   = rd_resp_st_s && g_rready_s;
    ar_hs_s      = s_arvalid_s && s.arready;
    r_hs_s       = s_rready_s && s.rvalid;

    s.araddr   = g_araddr_s;
    s.arprot   = rd_gnt_q ? m1.arprot : m0.arprot;
    s.arvalid  = s_arvalid_s;
    s.rready   = s_rready_s;
    m0.arready = rd_addr_st_s && !rd_gnt_q && s.arready;
    m1.arready = rd_addr_st_s && rd_gnt_q && s.arready;
    m0.rvalid  = rd_resp_st_s && !rd_gnt_q && s.rvalid;
    m1.rvalid  = rd_resp_st_s && rd_gnt_q && s.rvalid;
    m0.rdata   = !rd_gnt_q ? s.rdata : {DATA_W{1'b0}};
    m1.rdata   = rd_gnt_q ? s.rdata : {DATA_W{1'b0}};
    m0.rresp   = !rd_gnt_q ? s.rresp : 2'b00;
    m1.rresp   = rd_gnt_q ? s.rresp : 2'b00;
  end

  // Read FSM: grant is captured in IDLE and held until the R handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      rd_gnt_q   <= 1'b0;
      last_rd_q  <= 1'b1;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (m0.arvalid || m1.arvalid) begin
            rd_gnt_q   <= rd_pick_s;
            last_rd_q  <= rd_pick_s;
            rd_state_q <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (ar_hs_s) begin
            rd_state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs_s) begin
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // Write channel routing; AW and W are masked individually once accepted.
  always_comb begin
    wr_xfer_st_s = (wr_state_q == WR_XFER);
    wr_resp_st_s = (wr_state_q == WR_RESP);
    g_awaddr_s   = wr_gnt_q ? m1.awaddr : m0.awaddr;
    s_awvalid_s  = wr_xfer_st_s && !aw_done_q && (wr_gnt_q ? m1.awvalid : m0.awvalid);
    s_wvalid_s   = wr_xfer_st_s && !w_done_q && (wr_gnt_q ? m1.wvalid : m0.wvalid);
    awready_s    = wr_xfer_st_s && !aw_done_q && s.awready;
    wready_s     = wr_xfer_st_s && !w_done_q && s.wready;
    aw_hs_s      = s_awvalid_s && s.awready;
    w_hs_s       = s_wvalid_s && s.wready;
    aw_done_d    = aw_done_q || aw_hs_s;
    w_done_d     = w_done_q || w_hs_s;
    g_bready_s   = wr_gnt_q ? m1.bready : m0.bready;
    s_bready_s   = wr_resp_st_s && g_bready_s;
    b_hs_s       = s_bready_s && s.bvalid;

    s.awaddr   = g_awaddr_s;
    s.awprot   = wr_gnt_q ? m1.awprot : m0.awprot;
    s.awvalid  = s_awvalid_s;
    s.wdata    = wr_gnt_q ? m1.wdata : m0.wdata;
    s.wstrb    = wr_gnt_q ? m1.wstrb : m0.wstrb;
    s.wvalid   = s_wvalid_s;
    s.bready   = s_bready_s;
    m0.awready = awready_s && !wr_gnt_q;
    m1.awready = awready_s && wr_gnt_q;
    m0.wready  = wready_s && !wr_gnt_q;
    m1.wready  = wready_s && wr_gnt_q;
    m0.bvalid  = wr_resp_st_s && !wr_gnt_q && s.bvalid;
    m1.bvalid  = wr_resp_st_s && wr_gnt_q && s.bvalid;
    m0.bresp   = !wr_gnt_q ? s.bresp : 2'b00;
    m1.bresp   = wr_gnt_q ? s.bresp : 2'b00;
  end

  // Write FSM with AW/W completion flags; RESP is entered once both have been accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= WR_IDLE;
      wr_gnt_q   <= 1'b0;
      last_wr_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (m0.awvalid || m0.wvalid || m1.awvalid || m1.wvalid) begin
            wr_gnt_q   <= wr_pick_s;
            last_wr_q  <= wr_pick_s;
            wr_state_q <= WR_XFER;
          end
        end
        WR_XFER: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            wr_state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs_s) begin
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  axi4lite_arb2_chk u_chk_m0_ar (.clk_i(aclk), .rst_ni(aresetn), .valid_i(m0.arvalid), .ready_i(m0.arready));
  axi4lite_arb2_chk u_chk_m1_ar (.clk_i(aclk), .rst_ni(aresetn), .valid_i(m1.arvalid), .ready_i(m1.arready));
  axi4lite_arb2_chk u_chk_m0_aw (.clk_i(aclk), .rst_ni(aresetn), .valid_i(m0.awvalid), .ready_i(m0.awready));
  axi4lite_arb2_chk u_chk_m1_aw (.clk_i(aclk), .rst_ni(aresetn), .valid_i(m1.awvalid), .ready_i(m1.awready));
  axi4lite_arb2_chk u_chk_m0_w  (.clk_i(aclk), .rst_ni(aresetn), .valid_i(m0.wvalid),  .ready_i(m0.wready));
  axi4lite_arb2_chk u_chk_m1_w  (.clk_i(aclk), .rst_ni(aresetn), .valid_i(m1.wvalid),  .ready_i(m1.wready));

endmodule

// File: tb/tb_axi4lite_arb2.sv
// Scoreboard bench for axi4lite_arb2: directed master traffic, a simple downstream slave model,
// and a negedge monitor that pops expected transfers whenever a handshake is presented.
module tb_axi4lite_arb2;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int BUDGET = 60;

  localparam logic [AW-1:0] T2_ADDR [8] = '{
    48'h0000_0000_1000, 48'h0000_0000_2010, 48'h0000_0000_3020, 48'h0000_0000_4030,
    48'h0000_ABCD_0000, 48'h0000_ABCD_0110, 48'h7FFF_FFFF_FFE0, 48'hFFFF_FFFF_FFF0};
  localparam logic [DW-1:0] T2_DATA [8] = '{
    64'hD0D0_0000_0000_1000, 64'hD0D0_0000_0000_2010, 64'hD0D0_0000_0000_3020,
    64'hD0D0_0000_0000_4030, 64'hD0D0_0000_ABCD_0000, 64'hD0D0_0000_ABCD_0110,
    64'hD0D0_7FFF_FFFF_FFE0, 64'hD0D0_FFFF_FFFF_FFF0};
  localparam logic [1:0] T2_RESP [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4lite_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  axi4lite_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();
  axi4lite_arb2_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

  axi4lite_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn), .m0(m0_if), .m1(m1_if), .s(s_if));

  // Upstream master drive variables, indexed by master.
  logic [1:0]    ar_valid, aw_valid, w_valid, r_ready, b_ready;
  logic [AW-1:0] ar_addr [2];
  logic [AW-1:0] aw_addr [2];
  logic [2:0]    ar_prot [2];
  logic [2:0]    aw_prot [2];
  logic [DW-1:0] w_data [2];
  logic [SW-1:0] w_strb [2];

  assign m0_if.araddr = ar_addr[0];  assign m1_if.araddr = ar_addr[1];
  assign m0_if.arprot = ar_prot[0];  assign m1_if.arprot = ar_prot[1];
  assign m0_if.arvalid = ar_valid[0]; assign m1_if.arvalid = ar_valid[1];
  assign m0_if.awaddr = aw_addr[0];  assign m1_if.awaddr = aw_addr[1];
  assign m0_if.awprot = aw_prot[0];  assign m1_if.awprot = aw_prot[1];
  assign m0_if.awvalid = aw_valid[0]; assign m1_if.awvalid = aw_valid[1];
  assign m0_if.wdata = w_data[0];    assign m1_if.wdata = w_data[1];
  assign m0_if.wstrb = w_strb[0];    assign m1_if.wstrb = w_strb[1];
  assign m0_if.wvalid = w_valid[0];  assign m1_if.wvalid = w_valid[1];
  assign m0_if.rready = r_ready[0];  assign m1_if.rready = r_ready[1];
  assign m0_if.bready = b_ready[0];  assign m1_if.bready = b_ready[1];

  wire [1:0] ar_ready = {m1_if.arready, m0_if.arready};
  wire [1:0] aw_ready = {m1_if.awready, m0_if.awready};
  wire [1:0] w_ready  = {m1_if.wready, m0_if.wready};

  // Downstream slave model: R one cycle after AR, B once both AW and W were accepted.
  logic          s_ar_rdy, s_aw_rdy, s_w_rdy;
  logic          sl_rvalid, sl_bvalid, sl_aw_got, sl_w_got;
  logic [DW-1:0] sl_rdata;
  logic [1:0]    sl_rresp, sl_bresp;
  logic [AW-1:0] sl_awaddr;
  wire           sl_aw_hs = s_if.awvalid && s_if.awready;
  wire           sl_w_hs  = s_if.wvalid && s_if.wready;

  assign s_if.arready = s_ar_rdy;
  assign s_if.awready = s_aw_rdy;
  assign s_if.wready  = s_w_rdy;
  assign s_if.rvalid  = sl_rvalid;
  assign s_if.rdata   = sl_rdata;
  assign s_if.rresp   = sl_rresp;
  assign s_if.bvalid  = sl_bvalid;
  assign s_if.bresp   = sl_bresp;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sl_rvalid <= 1'b0; sl_bvalid <= 1'b0; sl_aw_got <= 1'b0; sl_w_got <= 1'b0;
      sl_rdata <= '0; sl_rresp <= 2'b00; sl_bresp <= 2'b00; sl_awaddr <= '0;
    end else begin
      if (s_if.arvalid && s_if.arready) begin
        sl_rvalid <= 1'b1;
        sl_rdata  <= {16'hD0D0, s_if.araddr};
        sl_rresp  <= s_if.araddr[5:4];
      end else if (s_if.rvalid && s_if.rready) begin
        sl_rvalid <= 1'b0;
      end
      if (s_if.bvalid && s_if.bready) sl_bvalid <= 1'b0;
      if ((sl_aw_got || sl_aw_hs) && (sl_w_got || sl_w_hs)) begin
        sl_bvalid <= 1'b1;
        sl_bresp  <= sl_aw_got ? sl_awaddr[5:4] : s_if.awaddr[5:4];
        sl_aw_got <= 1'b0;
        sl_w_got  <= 1'b0;
      end else begin
        if (sl_aw_hs) begin sl_aw_got <= 1'b1; sl_awaddr <= s_if.awaddr; end
        if (sl_w_hs) sl_w_got <= 1'b1;
      end
    end
  end

  // Scoreboard queues of expected transfers.
  logic [AW+2:0]   q_ar[$], q_aw[$];
  logic [SW+DW-1:0] q_w[$];
  logic [DW+1:0]   q_r0[$], q_r1[$];
  logic [1:0]      q_b0[$], q_b1[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_ar_hs = 0, n_aw_hs = 0, n_w_hs = 0, m1_noisy = 0;
  logic quiet_en = 1'b0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: handshake seen with nothing expected", name);
  endtask

  function automatic logic [14:0] ctrl_vec();
    return {s_if.arvalid, s_if.awvalid, s_if.wvalid, s_if.bready, s_if.rready,
            m0_if.arready, m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.rvalid,
            m1_if.arready, m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.rvalid};
  endfunction

  // Monitor: every handshake presented by the DUT is checked against the queue head.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_if.arvalid && s_if.arready) begin
        n_ar_hs <= n_ar_hs + 1;
        if (q_ar.size() == 0) unexpected("s_ar");
        else check("s_ar", 72'({s_if.arprot, s_if.araddr}), 72'(q_ar.pop_front()));
      end
      if (s_if.awvalid && s_if.awready) begin
        n_aw_hs <= n_aw_hs + 1;
        if (q_aw.size() == 0) unexpected("s_aw");
        else check("s_aw", 72'({s_if.awprot, s_if.awaddr}), 72'(q_aw.pop_front()));
      end
      if (s_if.wvalid && s_if.wready) begin
        n_w_hs <= n_w_hs + 1;
        if (q_w.size() == 0) unexpected("s_w");
        else check("s_w", 72'({s_if.wstrb, s_if.wdata}), 72'(q_w.pop_front()));
      end
      if (m0_if.rvalid && m0_if.rready) begin
        if (q_r0.size() == 0) unexpected("m0_r");
        else check("m0_r", 72'({m0_if.rresp, m0_if.rdata}), 72'(q_r0.pop_front()));
      end
      if (m1_if.rvalid && m1_if.rready) begin
        if (q_r1.size() == 0) unexpected("m1_r");
        else check("m1_r", 72'({m1_if.rresp, m1_if.rdata}), 72'(q_r1.pop_front()));
      end
      if (m0_if.bvalid && m0_if.bready) begin
        if (q_b0.size() == 0) unexpected("m0_b");
        else check("m0_b", 72'(m0_if.bresp), 72'(q_b0.pop_front()));
      end
      if (m1_if.bvalid && m1_if.bready) begin
        if (q_b1.size() == 0) unexpected("m1_b");
        else check("m1_b", 72'(m1_if.bresp), 72'(q_b1.pop_front()));
      end
      if (quiet_en && (m1_if.arready || m1_if.awready || m1_if.wready ||
                       m1_if.bvalid || m1_if.rvalid))
        m1_noisy <= m1_noisy + 1;
    end
  end

  task automatic m_read(input int mid, input logic [AW-1:0] addr, input logic [2:0] prot);
    int n = 0;
    ar_addr[mid] = addr;
    ar_prot[mid] = prot;
    ar_valid[mid] = 1'b1;
    do begin @(negedge aclk); n++; end while (!ar_ready[mid] && n < BUDGET);
    check($sformatf("m%0d_ar_accept", mid), 72'(ar_ready[mid]), 72'(1));
    @(posedge aclk); #1;
    ar_valid[mid] = 1'b0;
  endtask

  task automatic m_write(input int mid, input logic [AW-1:0] addr, input logic [2:0] prot,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int n = 0;
    logic a, w;
    aw_addr[mid] = addr; aw_prot[mid] = prot; w_data[mid] = data; w_strb[mid] = strb;
    aw_valid[mid] = 1'b1;
    w_valid[mid] = 1'b1;
    while ((aw_valid[mid] || w_valid[mid]) && n < BUDGET) begin
      @(negedge aclk);
      a = aw_valid[mid] && aw_ready[mid];
      w = w_valid[mid] && w_ready[mid];
      @(posedge aclk); #1;
      if (a) aw_valid[mid] = 1'b0;
      if (w) w_valid[mid] = 1'b0;
      n++;
    end
    check($sformatf("m%0d_wr_accept_pending", mid), 72'({aw_valid[mid], w_valid[mid]}), 72'(0));
    aw_valid[mid] = 1'b0;
    w_valid[mid] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_ar.size() + q_aw.size() + q_w.size() + q_r0.size() + q_r1.size() +
            q_b0.size() + q_b1.size()) != 0 && n < BUDGET) begin
      @(posedge aclk); n++;
    end
    check(name, 72'(q_ar.size() + q_aw.size() + q_w.size() + q_r0.size() + q_r1.size() +
                    q_b0.size() + q_b1.size()), 72'(0));
    @(posedge aclk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_aw, base_w, base_noisy, n;
    ar_valid = 2'b00; aw_valid = 2'b00; w_valid = 2'b00; r_ready = 2'b11; b_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      ar_addr[i] = '0; aw_addr[i] = '0; ar_prot[i] = 3'b000; aw_prot[i] = 3'b000;
      w_data[i] = '0; w_strb[i] = '0;
    end
    s_ar_rdy = 1'b1; s_aw_rdy = 1'b1; s_w_rdy = 1'b1;

    repeat (2) @(posedge aclk); #1;
    check("reset_ctrl", 72'(ctrl_vec()), 72'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single m0 read; s_arvalid rises one cycle after m0_arvalid, m1 stays silent.
    base_noisy = m1_noisy;
    quiet_en = 1'b1;
    q_ar.push_back({3'b000, 48'h0180_0000_0000});
    q_r0.push_back({2'b00, 64'hD0D0_0180_0000_0000});
    fork
      m_read(0, 48'h0180_0000_0000, 3'b000);
      begin
        @(negedge aclk); check("t1_s_arvalid_c0", 72'(s_if.arvalid), 72'(0));
        @(negedge aclk); check("t1_s_arvalid_c1", 72'(s_if.arvalid), 72'(1));
      end
    join
    wait_drain("t1_drain");
    repeat (2) @(posedge aclk); #1;
    quiet_en = 1'b0;
    check("t1_m1_silent", 72'(m1_noisy - base_noisy), 72'(0));

    // Simultaneous back-to-back reads from reset: grants alternate m0, m1, ...
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      q_ar.push_back({(i % 2 == 1) ? 3'b001 : 3'b000, T2_ADDR[i]});
      if (i % 2 == 0) q_r0.push_back({T2_RESP[i], T2_DATA[i]});
      else            q_r1.push_back({T2_RESP[i], T2_DATA[i]});
    end
    fork
      for (int k = 0; k < 4; k++) m_read(0, T2_ADDR[2*k], 3'b000);
      for (int k = 0; k < 4; k++) m_read(1, T2_ADDR[2*k+1], 3'b001);
    join
    wait_drain("t2_drain");

    // m1 write, W accepted three cycles before AW.
    s_aw_rdy = 1'b0;
    base_aw = n_aw_hs;
    base_w = n_w_hs;
    q_aw.push_back({3'b010, 48'h0000_0000_5530});
    q_w.push_back({8'hF0, 64'h1122_3344_5566_7788});
    q_b1.push_back(2'd3);
    fork
      m_write(1, 48'h0000_0000_5530, 3'b010, 64'h1122_3344_5566_7788, 8'hF0);
      begin
        n = 0;
        while (n_w_hs == base_w && n < BUDGET) begin @(posedge aclk); n++; end
        check("t3_w_first", 72'(n_w_hs - base_w), 72'(1));
        @(negedge aclk);
        check("t3_w_masked_aw_held", 72'({s_if.wvalid, s_if.awvalid}), 72'(2'b01));
        repeat (2) @(posedge aclk); #1;
        s_aw_rdy = 1'b1;
      end
    join
    wait_drain("t3_drain");
    check("t3_one_aw", 72'(n_aw_hs - base_aw), 72'(1));
    check("t3_one_w", 72'(n_w_hs - base_w), 72'(1));

    // m0 write concurrent with m1 read.
    q_aw.push_back({3'b000, 48'h0000_0000_6610});
    q_w.push_back({8'hFF, 64'hCAFE_F00D_DEAD_BEEF});
    q_b0.push_back(2'd1);
    q_ar.push_back({3'b001, 48'h0000_0000_7720});
    q_r1.push_back({2'd2, 64'hD0D0_0000_0000_7720});
    fork
      m_write(0, 48'h0000_0000_6610, 3'b000, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF);
      m_read(1, 48'h0000_0000_7720, 3'b001);
      begin
        @(negedge aclk); @(negedge aclk);
        check("t4_concurrent_valids", 72'({s_if.arvalid, s_if.awvalid, s_if.wvalid}), 72'(3'b111));
      end
    join
    wait_drain("t4_drain");

    // Response held back by m0_rready=0 for five cycles.
    r_ready[0] = 1'b0;
    q_ar.push_back({3'b000, 48'h0000_0000_8800});
    q_r0.push_back({2'd0, 64'hD0D0_0000_0000_8800});
    m_read(0, 48'h0000_0000_8800, 3'b000);
    n = 0;
    do begin @(negedge aclk); n++; end while (!m0_if.rvalid && n < BUDGET);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge aclk);
      check($sformatf("t5_hold_c%0d", c), 72'({m0_if.rvalid, s_if.rready, m0_if.rdata}),
            72'({1'b1, 1'b0, 64'hD0D0_0000_0000_8800}));
    end
    @(posedge aclk); #1;
    r_ready[0] = 1'b1;
    wait_drain("t5_drain");

    // Reset during write XFER with AW accepted and W pending.
    s_w_rdy = 1'b0;
    q_aw.push_back({3'b000, 48'h0000_0000_9900});
    aw_addr[1] = 48'h0000_0000_9900; aw_prot[1] = 3'b000;
    w_data[1] = 64'hFFFF_0000_FFFF_0000; w_strb[1] = 8'hFF;
    aw_valid[1] = 1'b1;
    w_valid[1] = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end while (!aw_ready[1] && n < BUDGET);
    check("t6_aw_accept", 72'(aw_ready[1]), 72'(1));
    @(posedge aclk); #1;
    aw_valid[1] = 1'b0;
    @(negedge aclk);
    check("t6_pre_reset", 72'({s_if.wvalid, s_if.awvalid}), 72'(2'b10));
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_async_reset_ctrl", 72'(ctrl_vec()), 72'(0));
    w_valid[1] = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    s_w_rdy = 1'b1;
    q_aw.push_back({3'b011, 48'h0000_0000_AA10});
    q_w.push_back({8'h0F, 64'h0102_0304_0506_0708});
    q_b1.push_back(2'd1);
    m_write(1, 48'h0000_0000_AA10, 3'b011, 64'h0102_0304_0506_0708, 8'h0F);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
